// File: rtl/cache_controller_nway.sv
// N-way set-associative write-through, no-write-allocate cache between the MEM stage
// and the SRAM controller: wrapping critical-word-first fill, round-robin victims, flush.
//   state   | meaning
//   S_IDLE  | serve read hits, dispatch misses/writes/flush
//   S_FILL  | fetch WORDS_PER_LINE words from SRAM into the victim way
//   S_WRITE | write-through store, update the hit word in place
//   S_FLUSH | invalidate one set per cycle
module cache_controller_nway #(
  parameter int WAYS           = 2,
  parameter int WORDS_PER_LINE = 2,
  parameter int SETS           = 64,
  parameter int ADDR_BITS      = 19
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic        flush,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        flush_busy,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  output logic        sram_read,
  output logic        sram_write,
  input  logic [31:0] sram_rdata,
  input  logic        sram_ready
);

  localparam int OFF_BITS = $clog2(WORDS_PER_LINE);
  localparam int IDX_BITS = $clog2(SETS);
  localparam int WAY_BITS = $clog2(WAYS);
  localparam int TAG_BITS = ADDR_BITS - 2 - OFF_BITS - IDX_BITS;
  localparam int TAG_LSB  = 2 + OFF_BITS + IDX_BITS;
  localparam int LINE_BITS = 30 - OFF_BITS;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_FLUSH} state_t;

  state_t                state_q;
  logic [OFF_BITS-1:0]   cnt_q;
  logic [OFF_BITS-1:0]   off_q;
  logic [WAY_BITS-1:0]   victim_q;
  logic                  from_ptr_q;
  logic [LINE_BITS-1:0]  line_q;
  logic [31:0]           crit_q;
  logic                  whit_q;
  logic [WAY_BITS-1:0]   whit_way_q;
  logic [IDX_BITS-1:0]   set_cnt_q;
  logic                  sram_read_q;
  logic                  sram_write_q;
  logic                  flush_busy_q;

  logic [SETS-1:0]       valid_q [WAYS];
  logic [WAY_BITS-1:0]   vptr_q  [SETS];
  logic [TAG_BITS-1:0]   tag_q   [WAYS][SETS];
  logic [31:0]           data_q  [WAYS][SETS][WORDS_PER_LINE];

  logic [OFF_BITS-1:0]   a_off;
  logic [IDX_BITS-1:0]   a_idx;
  logic [TAG_BITS-1:0]   a_tag;
  logic [IDX_BITS-1:0]   line_idx;
  logic [TAG_BITS-1:0]   line_tag;
  logic [OFF_BITS-1:0]   fill_word;
  logic                  fill_last;
  logic                  hit;
  logic [WAY_BITS-1:0]   hit_way;
  logic [31:0]           hit_word;
  logic                  inv_found;
  logic [WAY_BITS-1:0]   inv_way;
  logic [WAY_BITS-1:0]   victim_sel;

  assign a_off     = address[2 +: OFF_BITS];
  assign a_idx     = address[2+OFF_BITS +: IDX_BITS];
  assign a_tag     = address[TAG_LSB +: TAG_BITS];
  assign line_idx  = line_q[IDX_BITS-1:0];
  assign line_tag  = line_q[IDX_BITS +: TAG_BITS];
  assign fill_word = off_q + cnt_q;
  assign fill_last = (state_q == S_FILL) && sram_ready && (cnt_q == {OFF_BITS{1'b1}});

  // Descending scans so the lowest matching / invalid way wins.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[w][a_idx] && (tag_q[w][a_idx] == a_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(w);
      end
      if (!valid_q[w][a_idx]) begin
        inv_found = 1'b1;
        inv_way   = WAY_BITS'(w);
      end
    end
  end

  assign hit_word   = data_q[hit_way][a_idx][a_off];
  assign victim_sel = inv_found ? inv_way : vptr_q[a_idx];

  always_comb begin
    ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (flush || MEM_W_EN) ready = 1'b0;
        else if (MEM_R_EN)     ready = hit;
        else                   ready = 1'b1;
      end
      S_FILL:  ready = fill_last;
      S_WRITE: ready = sram_ready;
      default: ready = 1'b0;
    endcase
  end

  assign rdata        = fill_last ? crit_q : (hit ? hit_word : 32'h0);
  assign sram_address = (state_q == S_FILL) ? {line_q, fill_word, 2'b00} : address;
  assign sram_wdata   = wdata;
  assign sram_read    = sram_read_q;
  assign sram_write   = sram_write_q;
  assign flush_busy   = flush_busy_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      off_q        <= '0;
      victim_q     <= '0;
      from_ptr_q   <= 1'b0;
      line_q       <= '0;
      crit_q       <= '0;
      whit_q       <= 1'b0;
      whit_way_q   <= '0;
      set_cnt_q    <= '0;
      sram_read_q  <= 1'b0;
      sram_write_q <= 1'b0;
      flush_busy_q <= 1'b0;
      for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
      for (int s = 0; s < SETS; s++) vptr_q[s] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (flush) begin
            state_q      <= S_FLUSH;
            set_cnt_q    <= '0;
            flush_busy_q <= 1'b1;
          end else if (MEM_W_EN) begin
            state_q      <= S_WRITE;
            whit_q       <= hit;
            whit_way_q   <= hit_way;
            sram_write_q <= 1'b1;
          end else if (MEM_R_EN && !hit) begin
            state_q                   <= S_FILL;
            victim_q                  <= victim_sel;
            from_ptr_q                <= !inv_found;
            valid_q[victim_sel][a_idx] <= 1'b0;
            cnt_q                     <= '0;
            off_q                     <= a_off;
            line_q                    <= address[31:2+OFF_BITS];
            sram_read_q               <= 1'b1;
          end
        end
        S_FILL: begin
          if (sram_ready) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == '0) crit_q <= sram_rdata;
            if (fill_last) begin
              valid_q[victim_q][line_idx] <= 1'b1;
              if (from_ptr_q) vptr_q[line_idx] <= vptr_q[line_idx] + 1'b1;
              state_q     <= S_IDLE;
              sram_read_q <= 1'b0;
            end
          end
        end
        S_WRITE: begin
          if (sram_ready) begin
            state_q      <= S_IDLE;
            sram_write_q <= 1'b0;
          end
        end
        S_FLUSH: begin
          for (int w = 0; w < WAYS; w++) valid_q[w][set_cnt_q] <= 1'b0;
          vptr_q[set_cnt_q] <= '0;
          set_cnt_q         <= set_cnt_q + 1'b1;
          if (set_cnt_q == IDX_BITS'(SETS - 1)) begin
            state_q      <= S_IDLE;
            flush_busy_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if ((state_q == S_FILL) && sram_ready) begin
      data_q[victim_q][line_idx][fill_word] <= sram_rdata;
      if (fill_last) tag_q[victim_q][line_idx] <= line_tag;
    end
    if ((state_q == S_WRITE) && sram_ready && whit_q)
      data_q[whit_way_q][a_idx][a_off] <= wdata;
  end

endmodule

// File: tb/tb_cache_controller_nway.sv
// Directed bench for cache_controller_nway: a default 2-way/2-word instance and a
// 4-word-per-line instance, each behind a small SRAM responder with backing store.
module tb_cache_controller_nway;

  logic clk, rst;
  int checks, errors;

  logic [31:0] a_addr, a_wdata, a_rdata, a_saddr, a_swdata, a_srdata;
  logic        a_ren, a_wen, a_flush, a_ready, a_fbusy, a_sread, a_swrite, a_sready;
  logic [31:0] b_addr, b_wdata, b_rdata, b_saddr, b_swdata, b_srdata;
  logic        b_ren, b_wen, b_flush, b_ready, b_fbusy, b_sread, b_swrite, b_sready;

  logic [31:0] a_log[$];
  logic [31:0] b_log[$];
  logic [31:0] a_store [logic [31:0]];
  int a_lat, b_lat, a_wr_cnt;

  cache_controller_nway dut_a (
    .clk(clk), .rst(rst), .address(a_addr), .wdata(a_wdata), .MEM_R_EN(a_ren),
    .MEM_W_EN(a_wen), .flush(a_flush), .rdata(a_rdata), .ready(a_ready),
    .flush_busy(a_fbusy), .sram_address(a_saddr), .sram_wdata(a_swdata),
    .sram_read(a_sread), .sram_write(a_swrite), .sram_rdata(a_srdata),
    .sram_ready(a_sready));

  cache_controller_nway #(.WAYS(2), .WORDS_PER_LINE(4), .SETS(4), .ADDR_BITS(19)) dut_b (
    .clk(clk), .rst(rst), .address(b_addr), .wdata(b_wdata), .MEM_R_EN(b_ren),
    .MEM_W_EN(b_wen), .flush(b_flush), .rdata(b_rdata), .ready(b_ready),
    .flush_busy(b_fbusy), .sram_address(b_saddr), .sram_wdata(b_swdata),
    .sram_read(b_sread), .sram_write(b_swrite), .sram_rdata(b_srdata),
    .sram_ready(b_sready));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return 32'hAAAA_0000 ^ {2'b00, a[31:2]};
  endfunction

  // SRAM responders: one-cycle ready pulse two cycles after a strobe is seen.
  initial begin
    a_sready = 1'b0; a_srdata = '0; a_lat = 0; a_wr_cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (a_sready) begin
        a_sready = 1'b0; a_lat = 0;
      end else if (a_sread || a_swrite) begin
        if (a_lat == 1) begin
          a_sready = 1'b1;
          a_log.push_back(a_saddr);
          if (a_swrite) begin
            a_store[a_saddr] = a_swdata;
            a_wr_cnt++;
          end else begin
            a_srdata = a_store.exists(a_saddr) ? a_store[a_saddr] : mem_val(a_saddr);
          end
        end else a_lat++;
      end else a_lat = 0;
    end
  end

  initial begin
    b_sready = 1'b0; b_srdata = '0; b_lat = 0;
    forever begin
      @(posedge clk); #1;
      if (b_sready) begin
        b_sready = 1'b0; b_lat = 0;
      end else if (b_sread || b_swrite) begin
        if (b_lat == 1) begin
          b_sready = 1'b1;
          b_log.push_back(b_saddr);
          b_srdata = mem_val(b_saddr);
        end else b_lat++;
      end else b_lat = 0;
    end
  end

  task automatic do_read(input bit sel, input logic [31:0] addr,
                         output logic [31:0] data, output int lat);
    if (sel) begin b_addr = addr; b_ren = 1'b1; end
    else     begin a_addr = addr; a_ren = 1'b1; end
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      if (sel ? b_ready : a_ready) break;
      lat++;
    end
    data = sel ? b_rdata : a_rdata;
    checks++;
    if (lat >= 200) begin
      errors++;
      $display("FAIL read_timeout addr=%h waited=%0d required<200", addr, lat);
    end
    @(posedge clk); #1;
    a_ren = 1'b0; b_ren = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input bit both);
    int lat, wc0;
    wc0 = a_wr_cnt;
    a_addr = addr; a_wdata = data; a_wen = 1'b1; a_ren = both;
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      if (a_ready) break;
      lat++;
    end
    checks++;
    if (lat >= 200 || a_wr_cnt - wc0 != 1) begin
      errors++;
      $display("FAIL write_once addr=%h writes=%0d required=1 waited=%0d", addr, a_wr_cnt - wc0, lat);
    end
    @(posedge clk); #1;
    a_wen = 1'b0; a_ren = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    a_addr = '0; a_wdata = '0; a_ren = 0; a_wen = 0; a_flush = 0;
    b_addr = '0; b_wdata = '0; b_ren = 0; b_wen = 0; b_flush = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (a_ready !== 1'b1 || a_sread !== 1'b0 || a_swrite !== 1'b0 || a_fbusy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs ready=%b rd=%b wr=%b fb=%b required 1 0 0 0",
               a_ready, a_sread, a_swrite, a_fbusy);
    end
    checks++;
    if (a_rdata !== 32'h0 || b_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_rdata rdata=%h b_ready=%b required 0 1", a_rdata, b_ready);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fill_basic();
    logic [31:0] d; int lat, n0;
    n0 = a_log.size();
    do_read(0, 32'h4, d, lat);
    checks++;
    if (d !== 32'hAAAA_0001 || lat == 0) begin
      errors++; $display("FAIL fill2_data got=%h lat=%0d required AAAA0001 lat>0", d, lat);
    end
    checks++;
    if (a_log.size() != n0 + 2 || a_log[n0] !== 32'h4 || a_log[n0+1] !== 32'h0) begin
      errors++; $display("FAIL fill2_order n=%0d required 2 (4 then 0)", a_log.size() - n0);
    end
    do_read(0, 32'h4, d, lat);
    checks++;
    if (d !== 32'hAAAA_0001 || lat != 0 || a_log.size() != n0 + 2) begin
      errors++; $display("FAIL hit_repeat got=%h lat=%0d required AAAA0001 lat 0", d, lat);
    end
    do_read(0, 32'h0, d, lat);
    checks++;
    if (d !== 32'hAAAA_0000 || lat != 0) begin
      errors++; $display("FAIL hit_word0 got=%h lat=%0d required AAAA0000 lat 0", d, lat);
    end
  endtask

  task automatic test_wpl4();
    logic [31:0] d; int lat, n0;
    logic [31:0] exp_order [4];
    exp_order[0] = 32'h8; exp_order[1] = 32'hC; exp_order[2] = 32'h0; exp_order[3] = 32'h4;
    n0 = b_log.size();
    do_read(1, 32'h8, d, lat);
    checks++;
    if (d !== 32'hAAAA_0002) begin
      errors++; $display("FAIL fill4_crit got=%h required AAAA0002", d);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (b_log.size() < n0 + 4 || b_log[n0+i] !== exp_order[i]) begin
        errors++; $display("FAIL fill4_order i=%0d required %h", i, exp_order[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      do_read(1, exp_order[i], d, lat);
      checks++;
      if (d !== mem_val(exp_order[i]) || lat != 0) begin
        errors++; $display("FAIL fill4_hit addr=%h got=%h lat=%0d required %h lat 0",
                           exp_order[i], d, lat, mem_val(exp_order[i]));
      end
    end
  endtask

  task automatic test_replacement();
    logic [31:0] d; int lat;
    do_read(0, 32'h208, d, lat);
    do_read(0, 32'h408, d, lat);
    do_read(0, 32'h608, d, lat);
    checks++;
    if (d !== 32'hAAAA_0182 || lat == 0) begin
      errors++; $display("FAIL repl_c_fill got=%h lat=%0d required AAAA0182 lat>0", d, lat);
    end
    do_read(0, 32'h408, d, lat);
    checks++;
    if (d !== 32'hAAAA_0102 || lat != 0) begin
      errors++; $display("FAIL repl_b_kept got=%h lat=%0d required AAAA0102 lat 0", d, lat);
    end
    do_read(0, 32'h808, d, lat);
    do_read(0, 32'h608, d, lat);
    checks++;
    if (d !== 32'hAAAA_0182 || lat != 0) begin
      errors++; $display("FAIL repl_c_kept got=%h lat=%0d required AAAA0182 lat 0", d, lat);
    end
    do_read(0, 32'h808, d, lat);
    checks++;
    if (d !== 32'hAAAA_0202 || lat != 0) begin
      errors++; $display("FAIL repl_d_hit got=%h lat=%0d required AAAA0202 lat 0", d, lat);
    end
    do_read(0, 32'h208, d, lat);
    checks++;
    if (d !== 32'hAAAA_0082 || lat == 0) begin
      errors++; $display("FAIL repl_a_evicted got=%h lat=%0d required AAAA0082 lat>0", d, lat);
    end
  endtask

  task automatic test_write();
    logic [31:0] d; int lat;
    do_write(32'h4, 32'h1234_5678, 1'b0);
    checks++;
    if (a_log[a_log.size()-1] !== 32'h4) begin
      errors++; $display("FAIL write_addr got=%h required 00000004", a_log[a_log.size()-1]);
    end
    do_read(0, 32'h4, d, lat);
    checks++;
    if (d !== 32'h1234_5678 || lat != 0) begin
      errors++; $display("FAIL write_hit_update got=%h lat=%0d required 12345678 lat 0", d, lat);
    end
    do_read(0, 32'h0, d, lat);
    checks++;
    if (d !== 32'hAAAA_0000 || lat != 0) begin
      errors++; $display("FAIL write_neighbour got=%h lat=%0d required AAAA0000 lat 0", d, lat);
    end
    do_write(32'h1000, 32'hCAFE_0000, 1'b0);
    do_read(0, 32'h1000, d, lat);
    checks++;
    if (d !== 32'hCAFE_0000 || lat == 0) begin
      errors++; $display("FAIL write_no_alloc got=%h lat=%0d required CAFE0000 lat>0", d, lat);
    end
  endtask

  task automatic test_flush();
    logic [31:0] d; int lat, busy, bad;
    a_flush = 1'b1;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b0) begin
      errors++; $display("FAIL flush_req_ready got=%b required 0", a_ready);
    end
    @(posedge clk); #1;
    a_flush = 1'b0;
    busy = 0; bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (a_fbusy) begin
        busy++;
        if (a_ready) bad++;
      end else break;
    end
    checks++;
    if (busy != 64) begin
      errors++; $display("FAIL flush_duration got=%0d required 64", busy);
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL flush_ready_low cycles_ready_high=%0d required 0", bad);
    end
    @(posedge clk); #1;
    do_read(0, 32'h4, d, lat);
    checks++;
    if (d !== 32'h1234_5678 || lat == 0) begin
      errors++; $display("FAIL flush_miss got=%h lat=%0d required 12345678 lat>0", d, lat);
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [31:0] d; int lat, n0, n1;
    n0 = a_log.size();
    a_addr = 32'h10; a_ren = 1'b1;
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      if (a_log.size() > n0 && a_sread) break;
      lat++;
    end
    rst = 1'b0;
    #1;
    checks++;
    if (lat >= 200 || a_sread !== 1'b0 || a_ready !== 1'b0) begin
      errors++; $display("FAIL midfill_reset sread=%b ready=%b waited=%0d required 0 0", a_sread, a_ready, lat);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    n1 = a_log.size();
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      if (a_ready) break;
      lat++;
    end
    d = a_rdata;
    checks++;
    if (d !== 32'hAAAA_0004 || lat == 0 || lat >= 200) begin
      errors++; $display("FAIL midfill_refill got=%h lat=%0d required AAAA0004", d, lat);
    end
    checks++;
    if (a_log.size() != n1 + 2 || a_log[n1] !== 32'h10 || a_log[n1+1] !== 32'h14) begin
      errors++; $display("FAIL midfill_order n=%0d required 2 (10 then 14)", a_log.size() - n1);
    end
    @(posedge clk); #1;
    a_ren = 1'b0;
    do_read(0, 32'h14, d, lat);
    checks++;
    if (d !== 32'hAAAA_0005 || lat != 0) begin
      errors++; $display("FAIL midfill_hit got=%h lat=%0d required AAAA0005 lat 0", d, lat);
    end
  endtask

  task automatic test_rw_both();
    logic [31:0] d; int lat;
    do_write(32'h14, 32'h5555_AAAA, 1'b1);
    do_read(0, 32'h14, d, lat);
    checks++;
    if (d !== 32'h5555_AAAA || lat != 0) begin
      errors++; $display("FAIL rw_as_write got=%h lat=%0d required 5555AAAA lat 0", d, lat);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    checks = 0; errors = 0;
    test_reset();
    test_fill_basic();
    test_wpl4();
    test_replacement();
    test_write();
    test_flush();
    test_reset_mid_fill();
    test_rw_both();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_controller_nway.md
Name: cache_controller_nway

Overview:
- Parametrised N-way set-associative, write-through, no-write-allocate cache between the MEM stage and the SRAM controller.
- Generalises the existing 2-way/2-word controller in ways, line length and set count.
- Adds critical-word-first wrapping line fill, write-hit update in place (no invalidate), round-robin victim selection and a multi-cycle flush.
- Presents the same MEM-stage and SRAM-controller handshakes.

Parameters:
- WAYS, 2, associativity; power of 2, 2..8.
- WORDS_PER_LINE, 2, 32-bit words per line; power of 2, 2..16. OFF_BITS = log2(WORDS_PER_LINE).
- SETS, 64, sets per way; power of 2. IDX_BITS = log2(SETS).
- ADDR_BITS, 19, significant byte-address bits. TAG_BITS = ADDR_BITS-2-OFF_BITS-IDX_BITS; must be >= 1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- address  in  32  byte address; word offset = address[2+:OFF_BITS], index next IDX_BITS, tag next TAG_BITS; bits [1:0] and bits >= ADDR_BITS ignored
- wdata  in  32  store data
- MEM_R_EN  in  1  load request, held until ready
- MEM_W_EN  in  1  store request, held until ready
- flush  in  1  invalidate-all request
- rdata  out  32  load data, valid when ready=1 with MEM_R_EN
- ready  out  1  request complete / stage may advance
- flush_busy  out  1  flush in progress
- sram_address  out  32  SRAM word address
- sram_wdata  out  32  SRAM store data (= wdata)
- sram_read  out  1  SRAM read strobe
- sram_write  out  1  SRAM write strobe
- sram_rdata  in  32  SRAM read data, valid with sram_ready
- sram_ready  in  1  SRAM access done (one-cycle pulse)

Behaviour:
- Storage per set per way: valid, tag, WORDS_PER_LINE data words. Per set: victim pointer (log2(WAYS) bits).
- Reset (rst=0, immediate):
  - all valid=0, victim pointers=0, state IDLE, counters 0.
  - sram_read=0, sram_write=0, flush_busy=0.
  - ready=1 unless a request is pending.
- Hit: way w hits iff valid[w][index] and tag match. At most one way hits; the lowest index wins if corrupted.
- States: IDLE, FILL, WRITE, FLUSH. Entry priority from IDLE is flush > MEM_W_EN > MEM_R_EN.
- IDLE:
  - Read hit: ready=1 and rdata = hit word in the same cycle (0 wait states). No replacement-state change.
  - Read miss: ready=0; go to FILL.
    - Victim = lowest invalid way, else the set's victim pointer. Latch victim.
    - Clear the victim's valid bit. Set word counter cnt=0. Latch the miss offset.
  - Write: ready=0; go to WRITE. Latch the hit flag and hit way.
  - flush: ready=0; go to FLUSH with set counter 0.
- FILL:
  - sram_read=1.
  - sram_address = {address[31:2+OFF_BITS], (offset+cnt) mod WORDS_PER_LINE, 2'b00}.
  - Each sram_ready: write sram_rdata into the victim word (offset+cnt) mod WORDS_PER_LINE; cnt++. On cnt=0 also capture sram_rdata into the critical-word register.
  - On sram_ready with cnt=WORDS_PER_LINE-1:
    - Write the tag, set valid.
    - Advance the victim pointer by 1 mod WAYS, only if the victim came from the pointer.
    - ready=1 with rdata = critical-word register; next state IDLE.
  - Latency: WORDS_PER_LINE SRAM accesses plus one cycle.
- WRITE:
  - sram_write=1, sram_address=address, sram_wdata=wdata.
  - On sram_ready: ready=1; if the latched hit flag is set, update that cached word in the hit way (valid stays 1); next state IDLE.
  - Miss: no allocation.
- FLUSH:
  - flush_busy=1, ready=0.
  - Each cycle clear all ways' valid bits at the set counter and increment it.
  - Victim pointers are reset to 0.
  - After set SETS-1 return to IDLE. Duration: SETS cycles.
  - flush re-asserted during FLUSH is ignored.
- Outside FILL/WRITE: sram_read=0, sram_write=0, sram_address=address.
- MEM_R_EN and MEM_W_EN both high: treated as a write.
- Inputs must stay stable while ready=0. A request dropped mid-FILL still completes the line (fill is not abortable).
- Reset mid-FILL/WRITE/FLUSH: strobes drop at once; the partial line stays invalid.
- rdata=0 when no hit and not in FILL completion.

Test Plan:
- Reset, then read 0x0000_0004 (miss), SRAM returns 0xAAAA_0001 then 0xAAAA_0000 -> sram_address 0x4 then 0x0; ready on second sram_ready with rdata 0xAAAA_0001. Repeat the read -> ready same cycle, rdata 0xAAAA_0001, no sram_read.
- WORDS_PER_LINE=4, read 0x0000_0008 -> fill order 0x8, 0xC, 0x0, 0x4; all four words then hit.
- WAYS=2: fill tags A, B, C in set 0 -> C evicts A (way0); D evicts B (way1). A read again -> miss.
- Write 0x1234_5678 to a cached address -> one sram_write; following read hits with 0x1234_5678. Write to an uncached address -> read still misses.
- Pulse flush -> flush_busy high for exactly SETS cycles, ready=0 throughout; previously cached address then misses.
- Assert rst low mid-FILL -> sram_read drops immediately. After release, the same address misses and refills correctly.
